// File: rtl/cmp_sort_pkg.sv
// Shared types and helpers for the cmp_sort_ctrl sorting controller.
package cmp_sort_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  function automatic int cnt_width(input int depth);
    int w;
    w = $clog2(depth);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/cmp_swap.sv
// Combinational compare/swap cell: orders an unsigned pair, equal words stay put.
module cmp_swap #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             swap
);

  always_comb begin
    swap = a > b;
    lo   = swap ? b : a;
    hi   = swap ? a : b;
  end

endmodule

// File: rtl/cmp_sort_ctrl.sv
// Batch bubble-sort controller sharing one cmp_swap across a DEPTH-word buffer.
// Optional macro CMP_SORT_EARLY_EXIT_EN ends SORT after a pass with no swaps.
module cmp_sort_ctrl
  import cmp_sort_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             busy
);

  localparam int CW = cnt_width(DEPTH);
  localparam logic [CW-1:0] ONE   = CW'(1);
  localparam logic [CW-1:0] LAST  = CW'(DEPTH - 1);
  localparam logic [CW-1:0] LAST2 = CW'(DEPTH - 2);

  state_t          state, state_nxt;
  logic [CW-1:0]   wr_idx, rd_idx, j, pass;
  logic [CW-1:0]   j_nxt;
  logic [WIDTH-1:0] mem [DEPTH];

  logic [WIDTH-1:0] lo, hi;
  logic             swap;
  logic             pass_end, sort_done, early_stop;

  assign j_nxt = j + ONE;

  cmp_swap #(.WIDTH(WIDTH)) u_cmp_swap (
    .a    (mem[j]),
    .b    (mem[j_nxt]),
    .lo   (lo),
    .hi   (hi),
    .swap (swap)
  );

`ifdef CMP_SORT_EARLY_EXIT_EN
  logic swapped, pass_swapped;

  // The flag is logically cleared at j=0, so ignore its stored value there.
  assign pass_swapped = ((j == '0) ? 1'b0 : swapped) | swap;
  assign early_stop   = !pass_swapped;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      swapped <= 1'b0;
    end else if (state == SORT) begin
      swapped <= pass_swapped;
    end
  end
`else
  assign early_stop = 1'b0;
`endif

  assign pass_end  = (j == LAST2);
  assign sort_done = pass_end && ((pass == LAST2) || early_stop);

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    out_data  = '0;
    unique case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && (wr_idx == LAST)) state_nxt = SORT;
      end
      SORT: begin
        busy = 1'b1;
        if (sort_done) state_nxt = DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        out_data  = mem[rd_idx];
        if (out_ready && (rd_idx == LAST)) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= LOAD;
      wr_idx <= '0;
      rd_idx <= '0;
      j      <= '0;
      pass   <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        LOAD: if (in_valid) begin
          if (wr_idx == LAST) begin
            wr_idx <= '0;
            j      <= '0;
            pass   <= '0;
          end else begin
            wr_idx <= wr_idx + ONE;
          end
        end
        SORT: begin
          if (sort_done) begin
            j      <= '0;
            pass   <= '0;
            rd_idx <= '0;
          end else if (pass_end) begin
            j    <= '0;
            pass <= pass + ONE;
          end else begin
            j <= j_nxt;
          end
        end
        DRAIN: if (out_ready) begin
          if (rd_idx == LAST) begin
            rd_idx <= '0;
            wr_idx <= '0;
          end else begin
            rd_idx <= rd_idx + ONE;
          end
        end
        default: ;
      endcase
    end
  end

  // Buffer is never reset; a non-swapping compare leaves both words unchanged.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == LOAD && in_valid) begin
        mem[wr_idx] <= in_data;
      end else if (state == SORT && swap) begin
        mem[j]     <= lo;
        mem[j_nxt] <= hi;
      end
    end
  end

endmodule

// File: tb/tb_cmp_sort_ctrl.sv
// Self-checking bench for cmp_sort_ctrl (WIDTH=32, DEPTH=4) against a batch-level model.
module tb_cmp_sort_ctrl;

  localparam int W = 32;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready = 1'b0;
  logic         busy;

  cmp_sort_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Length of SORT for a batch: fixed, or passes-until-clean times (D-1).
  function automatic int sort_len(input logic [W-1:0] w [D]);
`ifdef CMP_SORT_EARLY_EXIT_EN
    logic [W-1:0] a [D];
    logic [W-1:0] t;
    int k;
    bit sw;
    a = w;
    k = 0;
    do begin
      sw = 1'b0;
      for (int i = 0; i < D - 1; i++)
        if (a[i] > a[i+1]) begin t = a[i]; a[i] = a[i+1]; a[i+1] = t; sw = 1'b1; end
      k++;
    end while (sw && k < D - 1);
    return k * (D - 1);
`else
    return (D - 1) * (D - 1);
`endif
  endfunction

  // Batch-level model: 0=accepting, 1=sorting, 2=emitting.
  bit           m_on = 1'b0;
  int           m_phase, m_n, m_left, m_rd;
  logic [W-1:0] m_buf [D];
  logic [W-1:0] m_exp [D];

  always @(posedge clk) begin
    if (!rst_n) begin
      m_on = 1'b1; m_phase = 0; m_n = 0;
    end else if (m_on) begin
      case (m_phase)
        0: if (in_valid) begin
          m_buf[m_n] = in_data;
          m_n++;
          if (m_n == D) begin
            m_exp = m_buf;
            m_exp.sort();
            m_left  = sort_len(m_buf);
            m_phase = 1;
          end
        end
        1: begin
          m_left--;
          if (m_left == 0) begin m_phase = 2; m_rd = 0; end
        end
        default: if (out_ready) begin
          m_rd++;
          if (m_rd == D) begin m_phase = 0; m_n = 0; end
        end
      endcase
    end
  end

  int           busy_cnt = 0;
  logic [W-1:0] out_log [$];

  always @(negedge clk) begin
    if (m_on) begin
      chk("in_ready", W'(in_ready), W'(m_phase == 0));
      chk("busy", W'(busy), W'(m_phase == 1));
      chk("out_valid", W'(out_valid), W'(m_phase == 2));
      chk("out_data", out_data, (m_phase == 2) ? m_exp[m_rd] : '0);
    end
    if (busy) busy_cnt++;
    if (out_valid && out_ready) out_log.push_back(out_data);
  end

  function automatic bit pat(input int mode, input int i);
    return (mode == 0) ? 1'b1 : (i % 3 == 0);
  endfunction

  task automatic load4(input logic [W-1:0] w [D], input bit dead);
    for (int i = 0; i < D; i++) begin
      in_valid = 1'b1; in_data = w[i];
      @(posedge clk); #1;
    end
    in_valid = dead;
    in_data  = dead ? 32'hDEAD : '0;
  endtask

  task automatic run_batch(input logic [W-1:0] w [D], input int mode, input bit dead);
    int n, i;
    bit was_valid, started;
    busy_cnt = 0;
    out_log.delete();
    load4(w, dead);
    started = 1'b0;
    for (int k = 0; k < 100 && !started; k++) begin
      @(posedge clk); #1;
      started = out_valid;
    end
    if (!started) chk("drain_timeout", 32'd0, 32'd1);
    n = 0; i = 0;
    while (started && n < D && i < 100) begin
      out_ready = pat(mode, i);
      in_valid  = dead && (i < 2);
      in_data   = 32'hDEAD;
      was_valid = out_valid;
      @(posedge clk); #1;
      if (out_ready && was_valid) n++;
      i++;
    end
    if (n < D) chk("drain_count", W'(n), W'(D));
    out_ready = 1'b0; in_valid = 1'b0;
    chk("in_ready_after_drain", W'(in_ready), 32'd1);
  endtask

  task automatic chk_log(input string name, input logic [W-1:0] e [D]);
    chk({name, "_len"}, W'(out_log.size()), W'(D));
    for (int i = 0; i < D && i < out_log.size(); i++) chk(name, out_log[i], e[i]);
  endtask

  localparam int SORT5 =
`ifdef CMP_SORT_EARLY_EXIT_EN
    3;
`else
    9;
`endif

  initial begin
    logic [W-1:0] w [D];
    logic [W-1:0] e [D];

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_in_ready", W'(in_ready), 32'd1);
    chk("rst_out_valid", W'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_busy", W'(busy), 32'd0);

    w = '{3, 1, 2, 0}; e = '{0, 1, 2, 3};
    run_batch(w, 0, 1'b0);
    chk("busy_len_3120", W'(busy_cnt), 32'd9);
    chk_log("out_3120", e);

    w = '{32'hFFFFFFFF, 0, 32'h80000000, 7}; e = '{0, 7, 32'h80000000, 32'hFFFFFFFF};
    run_batch(w, 0, 1'b0);
    chk_log("out_unsigned", e);

    w = '{5, 5, 5, 5}; e = '{5, 5, 5, 5};
    run_batch(w, 0, 1'b0);
    chk("busy_len_equal", W'(busy_cnt), W'(SORT5));
    chk_log("out_equal", e);

    w = '{4, 3, 2, 1}; e = '{1, 2, 3, 4};
    run_batch(w, 1, 1'b0);
    chk_log("out_stall", e);

    w = '{1, 2, 3, 4};
    load4(w, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    out_log.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_in_ready", W'(in_ready), 32'd1);
    chk("midrst_busy", W'(busy), 32'd0);
    chk("midrst_out_valid", W'(out_valid), 32'd0);
    chk("midrst_out_data", out_data, 32'd0);
    chk("midrst_no_output", W'(out_log.size()), 32'd0);
    w = '{9, 8, 7, 6}; e = '{6, 7, 8, 9};
    run_batch(w, 0, 1'b0);
    chk_log("out_after_rst", e);

    w = '{10, 40, 30, 20}; e = '{10, 20, 30, 40};
    run_batch(w, 0, 1'b1);
    chk_log("out_dead_batch", e);
    w = '{2, 9, 1, 5}; e = '{1, 2, 5, 9};
    run_batch(w, 1, 1'b0);
    chk_log("out_after_dead", e);

    for (int c = 0; c < 4000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      rst_n     = ($urandom_range(0, 499) != 0);
      @(posedge clk); #1;
    end
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
